sccb_ov5640_master: RTL and testbench



---
 rtl/sccb_ov5640_master.sv | 186 ++++++++++++++++++
 tb/tb_sccb_ov5640_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_ov5640_master.sv
// SCCB write master for the OV5640: issues ID / address-high / address-low / data
// writes on SIOC/SIOD and reports completion, NACK aborts and a saturating NACK count.
//
// state   | meaning
// S_IDLE  | bus free, waiting for start
// S_START | one cell: SIOD falls while SIOC is high
// S_BYTE  | 4 bytes x 9 bit cells, MSB first, ninth bit is the slave ACK
// S_STOP  | one cell: SIOD rises while SIOC is high
// S_GAP   | one cell of bus-free time before done
module sccb_ov5640_master #(
    parameter int unsigned CLK_FREQ_HZ  = 50000000,
    parameter int unsigned SCCB_FREQ_HZ = 100000,
    parameter logic [7:0]  DEV_ADDR     = 8'h78,
    parameter bit          CHECK_ACK    = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [7:0]  nack_cnt,
    output logic        sioc,
    output logic        siod_oe,
    input  logic        siod_in
);

    localparam int unsigned QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int          QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QDIV - 1);

    generate
        if (QDIV < 4) begin : g_qdiv_check
            $error("sccb_ov5640_master: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_STOP,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_quarter;
    logic [3:0]      r_bit;
    logic [1:0]      r_byte;
    logic [31:0]     r_frame;
    logic            r_nack;
    logic [1:0]      r_sync;
    logic            r_sioc;
    logic            r_siod_oe;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_nack_cnt;

    logic            w_last_bit;
    logic [3:0]      w_nxt_bit;
    logic [1:0]      w_nxt_byte;
    logic            w_cur_low;
    logic            w_nxt_low;

    function automatic logic f_sioc(input state_t s, input logic [1:0] q);
        f_sioc = ((s == S_BYTE) || (s == S_STOP)) ? q[1] : 1'b1;
    endfunction

    function automatic logic f_oe(input state_t s, input logic [1:0] q, input logic low);
        case (s)
            S_START: f_oe = q[1];
            S_BYTE:  f_oe = low;
            S_STOP:  f_oe = (q != 2'd3);
            default: f_oe = 1'b0;
        endcase
    endfunction

    // Frame bit index for (byte, bit) is 31 - (byte*8 + bit), i.e. the inverted concatenation.
    always_comb begin
        w_last_bit = (r_bit == 4'd8);
        w_nxt_bit  = w_last_bit ? 4'd0 : (r_bit + 4'd1);
        w_nxt_byte = w_last_bit ? (r_byte + 2'd1) : r_byte;
        w_cur_low  = (r_bit != 4'd8) && !r_frame[~{r_byte, r_bit[2:0]}];
        w_nxt_low  = (w_nxt_bit != 4'd8) && !r_frame[~{w_nxt_byte, w_nxt_bit[2:0]}];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], siod_in};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_qcnt     <= '0;
            r_quarter  <= 2'd0;
            r_bit      <= 4'd0;
            r_byte     <= 2'd0;
            r_frame    <= 32'd0;
            r_nack     <= 1'b0;
            r_sioc     <= 1'b1;
            r_siod_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_nack_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_frame   <= {DEV_ADDR & 8'hFE, address, data};
                    r_state   <= S_START;
                    r_qcnt    <= '0;
                    r_quarter <= 2'd0;
                    r_bit     <= 4'd0;
                    r_byte    <= 2'd0;
                    r_nack    <= 1'b0;
                    r_err     <= 1'b0;
                    r_sioc    <= 1'b1;
                    r_siod_oe <= 1'b0;
                end
            end else if (r_qcnt != Q_LAST) begin
                r_qcnt <= r_qcnt + QW'(1);
            end else begin
                r_qcnt    <= '0;
                r_quarter <= r_quarter + 2'd1;
                if ((r_state == S_BYTE) && (r_quarter == 2'd2) && w_last_bit) begin
                    r_nack <= r_sync[1];
                end
                if (r_quarter != 2'd3) begin
                    r_sioc    <= f_sioc(r_state, r_quarter + 2'd1);
                    r_siod_oe <= f_oe(r_state, r_quarter + 2'd1, w_cur_low);
                end else begin
                    // Cell boundary: pick the next cell and drive its q0 levels.
                    case (r_state)
                        S_START: begin
                            r_state   <= S_BYTE;
                            r_sioc    <= 1'b0;
                            r_siod_oe <= !r_frame[31];
                        end
                        S_BYTE: begin
                            if (w_last_bit && ((CHECK_ACK && r_nack) || (r_byte == 2'd3))) begin
                                r_state   <= S_STOP;
                                r_err     <= CHECK_ACK && r_nack;
                                r_sioc    <= 1'b0;
                                r_siod_oe <= 1'b1;
                            end else begin
                                r_bit     <= w_nxt_bit;
                                r_byte    <= w_nxt_byte;
                                r_sioc    <= 1'b0;
                                r_siod_oe <= w_nxt_low;
                            end
                        end
                        S_STOP: begin
                            r_state   <= S_GAP;
                            r_sioc    <= 1'b1;
                            r_siod_oe <= 1'b0;
                        end
                        default: begin
                            r_state   <= S_IDLE;
                            r_sioc    <= 1'b1;
                            r_siod_oe <= 1'b0;
                            r_done    <= 1'b1;
                            if (r_err && (r_nack_cnt != 8'hFF)) begin
                                r_nack_cnt <= r_nack_cnt + 8'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign ready    = (r_state == S_IDLE) & ~start;
    assign done     = r_done;
    assign err      = r_err;
    assign nack_cnt = r_nack_cnt;
    assign sioc     = r_sioc;
    assign siod_oe  = r_siod_oe;

endmodule

// File: tb/tb_sccb_ov5640_master.sv
// Bench for sccb_ov5640_master: bus-level monitor with an ACKing slave, a frame/latency
// model computed from request and NACK position, plus CHECK_ACK=0 and saturation instances.
module tb_sccb_ov5640_master;

    localparam int QD   = 10;
    localparam int QDS  = 4;
    localparam int CELL = 4 * QD;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_m = 1'b0, start_n = 1'b0, start_s = 1'b0;
    logic [15:0] address = 16'h0;
    logic [7:0]  data = 8'h0;

    logic       ready_m, done_m, err_m, sioc_m, oe_m, siod_in_m;
    logic       ready_n, done_n, err_n, sioc_n, oe_n, siod_in_n;
    logic       ready_s, done_s, err_s, sioc_s, oe_s, siod_in_s;
    logic [7:0] nack_m, nack_n, nack_s;

    logic slave_drive = 1'b0;
    wire  siod_m = ~(oe_m | slave_drive);
    assign siod_in_m = siod_m;
    assign siod_in_n = ~oe_n;
    assign siod_in_s = ~oe_s;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int cyc = 0;
    int exp_nack = 0;

    sccb_ov5640_master #(.CLK_FREQ_HZ(400), .SCCB_FREQ_HZ(10), .DEV_ADDR(8'h78), .CHECK_ACK(1'b1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_m), .address(address), .data(data),
        .ready(ready_m), .done(done_m), .err(err_m), .nack_cnt(nack_m),
        .sioc(sioc_m), .siod_oe(oe_m), .siod_in(siod_in_m));

    sccb_ov5640_master #(.CLK_FREQ_HZ(400), .SCCB_FREQ_HZ(10), .DEV_ADDR(8'h78), .CHECK_ACK(1'b0)) dut_na (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_n), .address(address), .data(data),
        .ready(ready_n), .done(done_n), .err(err_n), .nack_cnt(nack_n),
        .sioc(sioc_n), .siod_oe(oe_n), .siod_in(siod_in_n));

    sccb_ov5640_master #(.CLK_FREQ_HZ(400), .SCCB_FREQ_HZ(25), .DEV_ADDR(8'h78), .CHECK_ACK(1'b1)) dut_sat (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_s), .address(address), .data(data),
        .ready(ready_s), .done(done_s), .err(err_s), .nack_cnt(nack_s),
        .sioc(sioc_s), .siod_oe(oe_s), .siod_in(siod_in_s));

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Bus monitor + slave for the main instance.
    int         nack_byte = 4;
    logic       in_frame = 1'b0;
    int         bitcnt = 0;
    logic [7:0] shreg = 8'h0;
    logic [7:0] mon_q[$];
    int         n_starts = 0, n_stops = 0, st_cyc = 0;
    logic       p_sioc = 1'b1, p_siod = 1'b1;

    always @(sioc_m or siod_m or reset_n) begin
        if (!reset_n) begin
            in_frame    = 1'b0;
            slave_drive = 1'b0;
            bitcnt      = 0;
        end else begin
            if (p_sioc && sioc_m && p_siod && !siod_m) begin
                in_frame = 1'b1;
                bitcnt   = 0;
                n_starts++;
                st_cyc   = cyc;
            end else if (p_sioc && sioc_m && !p_siod && siod_m) begin
                in_frame    = 1'b0;
                slave_drive = 1'b0;
                n_stops++;
            end else if (!p_sioc && sioc_m && in_frame) begin
                if (bitcnt % 9 < 8) shreg = {shreg[6:0], siod_m};
                else mon_q.push_back(shreg);
                bitcnt++;
            end else if (p_sioc && !sioc_m && in_frame) begin
                slave_drive = (bitcnt % 9 == 8) && (bitcnt / 9 != nack_byte);
            end
        end
        p_sioc = sioc_m;
        p_siod = siod_m;
    end

    function automatic logic [31:0] exp_frame(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] id;
        id = 8'h78 & 8'hFE;
        return {id, a, d};
    endfunction

    function automatic logic [31:0] get_obs(input int base);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < 4; i++)
            if (base + i < mon_q.size()) v[31 - 8*i -: 8] = mon_q[base + i];
        return v;
    endfunction

    function automatic int exp_cells(input int nk, input bit chk);
        return (chk && nk < 4) ? (1 + 9 * (nk + 1) + 2) : 39;
    endfunction

    function automatic logic rd_done(input int w);
        case (w) 0: return done_m; 1: return done_n; default: return done_s; endcase
    endfunction
    function automatic logic rd_ready(input int w);
        case (w) 0: return ready_m; 1: return ready_n; default: return ready_s; endcase
    endfunction
    function automatic logic rd_err(input int w);
        case (w) 0: return err_m; 1: return err_n; default: return err_s; endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w) 0: start_m = v; 1: start_n = v; default: start_s = v; endcase
    endtask

    // Drives one request and collects observations; returns in the done cycle (+1 ns).
    task automatic xfer(input int w, input logic [15:0] a, input logic [7:0] d, input int pulse_at,
                        output int e0, output int lat, output logic e, output int rdy_bad,
                        output logic rdy_on_start);
        address = a;
        data    = d;
        set_start(w, 1'b1);
        #1;
        rdy_on_start = rd_ready(w);
        @(posedge clk_sys); #1;
        e0 = cyc;
        set_start(w, 1'b0);
        lat = -1;
        rdy_bad = 0;
        for (int i = 1; i <= 3000; i++) begin
            if (i == pulse_at) set_start(w, 1'b1);
            @(posedge clk_sys); #1;
            set_start(w, 1'b0);
            if (rd_done(w)) begin
                lat = cyc - e0;
                break;
            end
            if (rd_ready(w)) rdy_bad++;
        end
        e = rd_err(w);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({sioc_m, oe_m, done_m, err_m, nack_m} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", {sioc_m, oe_m, done_m, err_m, nack_m},
                     {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        reset_n = 1'b1;
        @(posedge clk_sys); #1;
        checks++;
        if ({ready_m, ready_n, ready_s, sioc_m} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1111", {ready_m, ready_n, ready_s, sioc_m});
        end
    endtask

    task automatic test_single_write();
        int e0, lat, rb, base, s0, p0;
        logic e, ros;
        nack_byte = 4;
        base = mon_q.size(); s0 = n_starts; p0 = n_stops;
        xfer(0, 16'h3008, 8'h82, 0, e0, lat, e, rb, ros);
        checks++;
        if (ros !== 1'b0) begin errors++; $display("FAIL single_ready_comb: got %b required 0", ros); end
        checks++;
        if (lat != 39 * CELL) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, 39 * CELL); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", e); end
        checks++;
        if (rb != 0) begin errors++; $display("FAIL single_ready_busy: got %0d cycles high required 0", rb); end
        checks++;
        if (ready_m !== 1'b1) begin errors++; $display("FAIL single_ready_done: got %b required 1", ready_m); end
        checks++;
        if (mon_q.size() - base != 4 || get_obs(base) !== 32'h78300882) begin
            errors++;
            $display("FAIL single_bytes: got %0d bytes %h required 4 bytes 78300882", mon_q.size() - base, get_obs(base));
        end
        checks++;
        if (n_starts - s0 != 1 || n_stops - p0 != 1) begin
            errors++;
            $display("FAIL single_start_stop: got starts=%0d stops=%0d required 1/1", n_starts - s0, n_stops - p0);
        end
        checks++;
        if (st_cyc != e0 + 2 * QD) begin errors++; $display("FAIL single_start_time: got %0d required %0d", st_cyc, e0 + 2 * QD); end
        @(posedge clk_sys); #1;
        checks++;
        if (done_m !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b required 0", done_m); end
    endtask

    task automatic test_handshake();
        int e0, lat, rb, base, s0;
        logic e, ros;
        nack_byte = 4;
        base = mon_q.size(); s0 = n_starts;
        xfer(0, 16'hA55A, 8'h3C, 300, e0, lat, e, rb, ros);
        checks++;
        if (ros !== 1'b0) begin errors++; $display("FAIL hs_ready_comb: got %b required 0", ros); end
        checks++;
        if (lat != 39 * CELL) begin errors++; $display("FAIL hs_latency: got %0d required %0d", lat, 39 * CELL); end
        checks++;
        if (n_starts - s0 != 1 || get_obs(base) !== exp_frame(16'hA55A, 8'h3C)) begin
            errors++;
            $display("FAIL hs_single_txn: got starts=%0d frame %h required 1 frame %h", n_starts - s0,
                     get_obs(base), exp_frame(16'hA55A, 8'h3C));
        end
        repeat (3) @(posedge clk_sys);
        #1;
        checks++;
        if (n_starts - s0 != 1 || ready_m !== 1'b1) begin
            errors++;
            $display("FAIL hs_no_extra: got starts=%0d ready=%b required 1/1", n_starts - s0, ready_m);
        end
    endtask

    task automatic test_back_to_back();
        int e0a, la, e0b, lb, rb, base;
        logic e, ros;
        nack_byte = 4;
        base = mon_q.size();
        xfer(0, 16'h1234, 8'h56, 0, e0a, la, e, rb, ros);
        xfer(0, 16'hFEDC, 8'hBA, 0, e0b, lb, e, rb, ros);
        checks++;
        if (e0b != e0a + la + 1) begin errors++; $display("FAIL b2b_accept: got %0d required %0d", e0b, e0a + la + 1); end
        checks++;
        if (st_cyc != e0b + 2 * QD) begin errors++; $display("FAIL b2b_start_time: got %0d required %0d", st_cyc, e0b + 2 * QD); end
        checks++;
        if (lb != 39 * CELL) begin errors++; $display("FAIL b2b_latency: got %0d required %0d", lb, 39 * CELL); end
        checks++;
        if (get_obs(base) !== exp_frame(16'h1234, 8'h56) || get_obs(base + 4) !== exp_frame(16'hFEDC, 8'hBA)) begin
            errors++;
            $display("FAIL b2b_bytes: got %h %h required %h %h", get_obs(base), get_obs(base + 4),
                     exp_frame(16'h1234, 8'h56), exp_frame(16'hFEDC, 8'hBA));
        end
    endtask

    task automatic test_nack();
        int e0, lat, rb, base, p0;
        logic e, ros;
        nack_byte = 1;
        base = mon_q.size(); p0 = n_stops;
        xfer(0, 16'h4300, 8'h30, 0, e0, lat, e, rb, ros);
        exp_nack = (exp_nack < 255) ? exp_nack + 1 : 255;
        checks++;
        if (lat != 21 * CELL) begin errors++; $display("FAIL nack_latency: got %0d required %0d", lat, 21 * CELL); end
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL nack_err: got %b required 1", e); end
        checks++;
        if (nack_m !== 8'(exp_nack)) begin errors++; $display("FAIL nack_cnt: got %0d required %0d", nack_m, exp_nack); end
        checks++;
        if (mon_q.size() - base != 2 || get_obs(base) !== 32'h78430000 || n_stops - p0 != 1) begin
            errors++;
            $display("FAIL nack_bus: got %0d bytes %h stops=%0d required 2 bytes 78430000 stops=1",
                     mon_q.size() - base, get_obs(base), n_stops - p0);
        end
        repeat (5) @(posedge clk_sys);
        #1;
        checks++;
        if (err_m !== 1'b1) begin errors++; $display("FAIL nack_err_hold: got %b required 1", err_m); end
    endtask

    task automatic test_random();
        int e0, lat, rb, base, nk, nb;
        logic e, ros;
        logic [15:0] a;
        logic [7:0] d;
        logic [31:0] mask;
        for (int t = 0; t < 6; t++) begin
            a  = 16'($urandom);
            d  = 8'($urandom);
            nk = $urandom_range(0, 4);
            nack_byte = nk;
            base = mon_q.size();
            xfer(0, a, d, 0, e0, lat, e, rb, ros);
            if (nk < 4) exp_nack = (exp_nack < 255) ? exp_nack + 1 : 255;
            nb   = (nk < 4) ? nk + 1 : 4;
            mask = 32'hFFFFFFFF << (8 * (4 - nb));
            checks++;
            if (lat != exp_cells(nk, 1'b1) * CELL) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, exp_cells(nk, 1'b1) * CELL);
            end
            checks++;
            if (e !== (nk < 4)) begin errors++; $display("FAIL rand_err[%0d]: got %b required %b", t, e, nk < 4); end
            checks++;
            if (nack_m !== 8'(exp_nack)) begin errors++; $display("FAIL rand_nack_cnt[%0d]: got %0d required %0d", t, nack_m, exp_nack); end
            checks++;
            if (mon_q.size() - base != nb || get_obs(base) !== (exp_frame(a, d) & mask)) begin
                errors++;
                $display("FAIL rand_bytes[%0d]: got %0d bytes %h required %0d bytes %h", t, mon_q.size() - base,
                         get_obs(base), nb, exp_frame(a, d) & mask);
            end
        end
    endtask

    task automatic test_check_ack_off();
        int e0, lat, rb;
        logic e, ros;
        xfer(1, 16'h3103, 8'h11, 0, e0, lat, e, rb, ros);
        checks++;
        if (lat != exp_cells(0, 1'b0) * CELL) begin errors++; $display("FAIL noack_latency: got %0d required %0d", lat, 39 * CELL); end
        checks++;
        if (e !== 1'b0 || nack_n !== 8'h00) begin
            errors++; $display("FAIL noack_err_cnt: got err=%b cnt=%0d required 0/0", e, nack_n);
        end
    endtask

    task automatic test_reset_mid();
        int e0, lat, rb, base, s0, dcount;
        logic e, ros;
        nack_byte = 4;
        address = 16'h3820; data = 8'h47;
        start_m = 1'b1;
        @(posedge clk_sys); #1;
        start_m = 1'b0;
        repeat (200) @(posedge clk_sys);
        #3;
        reset_n = 1'b0;
        #1;
        exp_nack = 0;
        checks++;
        if ({sioc_m, oe_m, done_m, err_m, nack_m} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required %b", {sioc_m, oe_m, done_m, err_m, nack_m},
                     {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(posedge clk_sys); #1;
        checks++;
        if (ready_m !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", ready_m); end
        dcount = 0;
        for (int i = 0; i < 1600; i++) begin
            @(posedge clk_sys); #1;
            if (done_m) dcount++;
        end
        checks++;
        if (dcount != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses required 0", dcount); end
        base = mon_q.size(); s0 = n_starts;
        xfer(0, 16'h3008, 8'h02, 0, e0, lat, e, rb, ros);
        checks++;
        if (lat != 39 * CELL || e !== 1'b0) begin
            errors++; $display("FAIL rstmid_next_write: got lat=%0d err=%b required %0d/0", lat, e, 39 * CELL);
        end
        checks++;
        if (get_obs(base) !== exp_frame(16'h3008, 8'h02) || n_starts - s0 != 1) begin
            errors++;
            $display("FAIL rstmid_next_bytes: got %h starts=%0d required %h starts=1", get_obs(base), n_starts - s0,
                     exp_frame(16'h3008, 8'h02));
        end
    endtask

    task automatic test_nack_saturation();
        int e0, lat, rb, expc;
        logic e, ros;
        for (int i = 0; i < 260; i++) begin
            xfer(2, 16'($urandom), 8'($urandom), 0, e0, lat, e, rb, ros);
            expc = (i + 1 < 255) ? i + 1 : 255;
            checks++;
            if (lat != exp_cells(0, 1'b1) * 4 * QDS) begin
                errors++; $display("FAIL sat_latency[%0d]: got %0d required %0d", i, lat, exp_cells(0, 1'b1) * 4 * QDS);
            end
            checks++;
            if (e !== 1'b1) begin errors++; $display("FAIL sat_err[%0d]: got %b required 1", i, e); end
            checks++;
            if (nack_s !== 8'(expc)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d required %0d", i, nack_s, expc); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_handshake();
        test_back_to_back();
        test_nack();
        test_random();
        test_check_ack_off();
        test_reset_mid();
        test_nack_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
